// File: rtl/branch_resolve_unit_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit_if
//
// Purpose: groups the request and result handshakes of branch_resolve_unit
//          into one bundle.
//
// Handshake rule (applies to both channels): a transfer happens on a rising
// clock edge where valid && ready are both 1. Once valid is asserted, the
// payload stays stable until that transfer happens. ready may depend
// combinationally on the receiver's state, but never on valid.
//
// Signals:
//   in_valid / in_ready    request handshake (producer -> unit)
//   br_type, op_a, op_b    condition code and source operands
//   pc, target             branch PC and taken target
//   pred_taken             fetch-stage prediction for this branch
//   kill                   drop the held result and refuse input this cycle
//   out_valid / out_ready  result handshake (unit -> consumer)
//   taken, mispredict      resolved outcome and prediction check
//   redirect_pc            next fetch address for the front end
//
// Modports:
//   master  producer/consumer side (execute stage, front end, testbench)
//   slave   branch_resolve_unit
// ---------------------------------------------------------------------------
interface branch_resolve_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        br_type;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic              pred_taken;
    logic              kill;
    logic              out_valid;
    logic              out_ready;
    logic              taken;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output in_valid, br_type, op_a, op_b, pc, target, pred_taken, kill,
               out_ready,
        input  in_ready, out_valid, taken, mispredict, redirect_pc
    );

    modport slave (
        input  in_valid, br_type, op_a, op_b, pc, target, pred_taken, kill,
               out_ready,
        output in_ready, out_valid, taken, mispredict, redirect_pc
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose: execute-stage branch resolution. Accepts one branch per cycle,
//          evaluates its condition, compares the outcome with the fetch-stage
//          prediction, and holds the registered result (taken, mispredict,
//          redirect_pc) in a single-entry output register until the consumer
//          takes it.
//
// Parameters:
//   DATA_W   operand width (>= 2)
//   ADDR_W   PC / target width
//   PC_STEP  fall-through increment added to pc
//   CNT_W    statistics counter width (exists only with BRU_STATS_EN)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   bus        branch_resolve_unit_if.slave (request + result handshakes)
//   stat_branches, stat_mispredicts
//              saturating counters (exist only with BRU_STATS_EN)
//
// Build option: define BRU_STATS_EN to add the statistics counters.
//
// Condition codes (0..3 keep the legacy encoding):
//   0 none  1 BNE  2 JMP  3 BEZ  4 BEQ  5 BLT  6 BGE  7 BLTU
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int PC_STEP = 4
`ifdef BRU_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_unit_if.slave bus
`ifdef BRU_STATS_EN
    ,
    output logic [CNT_W-1:0]     stat_branches,
    output logic [CNT_W-1:0]     stat_mispredicts
`endif
);

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BNE  = 3'd1,
        BR_JMP  = 3'd2,
        BR_BEZ  = 3'd3,
        BR_BEQ  = 3'd4,
        BR_BLT  = 3'd5,
        BR_BGE  = 3'd6,
        BR_BLTU = 3'd7
    } br_type_e;

    // -----------------------------------------------------------------------
    // Condition evaluation (purely combinational on the request payload)
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    br_type_e          br_type;

    assign op_a    = bus.op_a;
    assign op_b    = bus.op_b;
    assign br_type = br_type_e'(bus.br_type);

    logic              eq_ab;
    logic              a_zero;
    logic              lt_signed;
    logic              lt_unsigned;
    logic              taken_calc;
    logic              mispredict_calc;
    logic [ADDR_W-1:0] fall_through;
    logic [ADDR_W-1:0] redirect_calc;

    assign eq_ab       = (op_a == op_b);
    assign a_zero      = (op_a == '0);
    assign lt_signed   = ($signed(op_a) < $signed(op_b));
    assign lt_unsigned = (op_a < op_b);

    always_comb begin
        taken_calc = 1'b0;
        unique case (br_type)
            BR_NONE: taken_calc = 1'b0;
            BR_BNE:  taken_calc = !eq_ab;
            BR_JMP:  taken_calc = 1'b1;
            BR_BEZ:  taken_calc = a_zero;
            BR_BEQ:  taken_calc = eq_ab;
            BR_BLT:  taken_calc = lt_signed;
            BR_BGE:  taken_calc = !lt_signed;
            BR_BLTU: taken_calc = lt_unsigned;
            default: taken_calc = 1'b0;
        endcase
    end

    // A non-branch (code 0) predicted taken is a mispredict: fetch went to a
    // bogus target and must be pulled back to the fall-through address.
    // The addition wraps naturally at ADDR_W bits.
    assign mispredict_calc = (taken_calc != bus.pred_taken);
    assign fall_through    = bus.pc + ADDR_W'(PC_STEP);
    assign redirect_calc   = taken_calc ? bus.target : fall_through;

    // -----------------------------------------------------------------------
    // Single-entry output register
    // -----------------------------------------------------------------------
    logic              out_valid_q,   out_valid_d;
    logic              taken_q,       taken_d;
    logic              mispredict_q,  mispredict_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;

    logic in_ready;
    logic accept;
    logic drain;

    // The slot is free when empty or being emptied this cycle; kill blocks
    // acceptance outright so a killed cycle can never load a new entry.
    assign in_ready = !bus.kill && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign drain    = out_valid_q && bus.out_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        taken_d       = taken_q;
        mispredict_d  = mispredict_q;
        redirect_pc_d = redirect_pc_q;

        if (bus.kill) begin
            // Payload is left as-is; only the valid bit is dropped.
            out_valid_d = 1'b0;
        end else if (accept) begin
            // Covers both an empty slot and a simultaneous drain + refill.
            out_valid_d   = 1'b1;
            taken_d       = taken_calc;
            mispredict_d  = mispredict_calc;
            redirect_pc_d = redirect_calc;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            taken_q       <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            taken_q       <= taken_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.taken       = taken_q;
    assign bus.mispredict  = mispredict_q;
    assign bus.redirect_pc = redirect_pc_q;

`ifdef BRU_STATS_EN
    // -----------------------------------------------------------------------
    // Saturating statistics counters. They count at the accept edge, so a
    // later kill of the held entry does not undo the count.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] branches_q,    branches_d;
    logic [CNT_W-1:0] mispredicts_q, mispredicts_d;

    always_comb begin
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;

        if (accept && (br_type != BR_NONE) && (branches_q != '1)) begin
            branches_d = branches_q + 1'b1;
        end
        if (accept && mispredict_calc && (mispredicts_q != '1)) begin
            mispredicts_d = mispredicts_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;
`else
    // Statistics build option disabled: no counters, no stat ports.
`endif

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, pipelined successor to the combinational branch condition check. Sits in the execute stage: it accepts one branch per cycle over a valid/ready handshake, evaluates an extended condition set (legacy JMP/BEZ/BNE codes preserved, plus BEQ and signed/unsigned compares), and registers the outcome. It compares the outcome against the fetch-stage prediction and emits the mispredict flag and redirect PC for the front end. Optional saturating statistics counters track branches and mispredicts.

## Interface
- DATA_W, 32, operand width in bits (>= 2)
- ADDR_W, 32, PC/target width in bits
- PC_STEP, 4, sequential PC increment for the fall-through address
- CNT_W, 16, statistics counter width (used only with BRU_STATS_EN)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  branch request present
- in_ready  output  1  unit can accept this cycle
- br_type  input  3  condition code (see Operation)
- op_a, op_b  input  DATA_W  source register values
- pc  input  ADDR_W  PC of the branch
- target  input  ADDR_W  branch target
- pred_taken  input  1  fetch-stage prediction
- kill  input  1  discard held result and block acceptance this cycle
- out_valid  output  1  registered result present
- out_ready  input  1  consumer takes result
- taken  output  1  resolved outcome
- mispredict  output  1  taken != pred_taken for the held entry
- redirect_pc  output  ADDR_W  taken ? target : pc + PC_STEP (wraps mod 2^ADDR_W)
- stat_branches, stat_mispredicts  output  CNT_W  counters (only with BRU_STATS_EN)

## Operation
- br_type: 0 none (taken=0), 1 BNE (op_a != op_b), 2 JMP (1), 3 BEZ (op_a == 0), 4 BEQ (op_a == op_b), 5 BLT signed, 6 BGE signed, 7 BLTU unsigned. Codes 0–3 match the legacy encoding exactly.
- Single-entry output register. in_ready = !kill && (!out_valid || out_ready).
- Accept on in_valid && in_ready: the register loads taken, mispredict, and redirect_pc; out_valid <= 1.
- Output handshake out_valid && out_ready with no new accept: out_valid <= 0.
- Simultaneous drain and accept: the new entry replaces the old one; out_valid stays 1.
- kill (highest priority below rst): out_valid <= 0 next cycle; no accept in that cycle, whatever in_valid is.
- For br_type 0 with pred_taken=1, mispredict=1 and redirect_pc = pc + PC_STEP. This corrects a false prediction on a non-branch.
- While out_valid=0, taken and mispredict hold their last values. Consumers qualify them with out_valid.
- Reset: out_valid, taken, mispredict = 0; redirect_pc = 0; counters = 0. Reset mid-transfer drops the held entry.

## Timing
- Latency: 1 cycle from accept edge to out_valid.
- Throughput: 1 branch/cycle while out_ready=1.
- in_ready is combinational from out_valid, out_ready, and kill. There is no combinational path from in_valid to out_valid.
- Held outputs are stable while out_valid=1 && out_ready=0.

## Configuration
- BRU_STATS_EN defined:
  - stat_branches increments on each accept with br_type != 0.
  - stat_mispredicts increments on each accept whose computed mispredict=1.
  - Both counters saturate at 2^CNT_W-1.
  - Both update on the accept edge and are not affected by kill after acceptance.
  - Both clear only on rst.
- BRU_STATS_EN undefined: the counters and both stat ports are absent. Core behaviour is identical.

## Test plan
- Legacy codes, DATA_W=32, pred_taken=0:
  - BNE 5/5 -> taken=0.
  - BNE 5/6 -> taken=1, mispredict=1.
  - JMP -> taken=1.
  - BEZ op_a=0 -> taken=1; BEZ op_a=1 -> taken=0.
- Signed vs unsigned, op_a=0xFFFFFFFF, op_b=1:
  - BLT -> taken=1.
  - BLTU -> taken=0.
  - BGE -> taken=0.
- Back-pressure:
  - out_ready=0, accept A; in_ready falls; A held stable 3 cycles.
  - Then out_ready=1 with B valid -> A drains and B loads in the same cycle; out_valid stays 1.
- Wrap and redirect: pc=0xFFFFFFFC, BEQ 3/4, pred_taken=1 -> taken=0, mispredict=1, redirect_pc=0x00000000.
- kill/reset: kill while holding an entry, with in_valid=1 -> out_valid=0 next cycle, input not accepted. rst mid-stream -> all outputs 0 the next cycle.
- BRU_STATS_EN, CNT_W=2:
  - 5 accepted mispredicting BNEs -> stat_branches=3 and stat_mispredicts=3 (saturated).
  - br_type 0 accepts do not increment stat_branches.
